// File: rtl/uart_echo_fifo.sv
// UART echo path: oversampling receiver, English/Thai (ASCII / TIS-620) character
// filter, echo FIFO with sticky overflow, and a transmitter with hold-off control.
module uart_echo_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_EN  = 1
) (
  input  logic                        baud,
  input  logic                        reset,
  input  logic                        RsRx,
  input  logic                        tx_hold,
  output logic                        RsTx,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        received,
  output logic                        frame_err,
  output logic                        is_thai,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(OVERSAMPLE - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  function automatic logic char_accept(input logic [DATA_BITS-1:0] b);
    logic [7:0] b8;
    b8 = 8'(b);
    if (FILTER_EN == 0 || DATA_BITS != 8) return 1'b1;
    return ((b8 >= 8'h20) && (b8 <= 8'h7E)) || (b8 >= 8'hA0);
  endfunction

  function automatic logic char_thai(input logic [DATA_BITS-1:0] b);
    logic [7:0] b8;
    b8 = 8'(b);
    return (DATA_BITS == 8) && (b8 >= 8'hA0);
  endfunction

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_done, rx_ferr;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_pop;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 received_q, frame_err_q, is_thai_q;
  logic                 accept, full, push, drop;

  assign accept = char_accept(rx_shift_q);
  assign full   = (count_q == DEPTH_C);
  assign push   = rx_done && accept && !full;
  assign drop   = rx_done && accept && full;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == OS_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = R_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == OS_LAST) begin
          rx_cnt_d = '0;
          if (sync2_q) begin
            rx_done    = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = R_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_WAIT: begin
        if (sync2_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // The stop bit ends one cycle early; the IDLE cycle supplies its last tick so
  // a queued byte can start on the very next edge with no extra idle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        tx_line_d = 1'b1;
        if (count_q != '0 && !tx_hold) begin
          tx_pop     = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_line_d  = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == OS_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == OS_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_line_d  = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, tx_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge baud or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      tx_state_q  <= T_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_line_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      data_out_q  <= '0;
      received_q  <= 1'b0;
      frame_err_q <= 1'b0;
      is_thai_q   <= 1'b0;
    end else begin
      sync1_q     <= RsRx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_line_q   <= tx_line_d;
      count_q     <= count_d;
      received_q  <= rx_done;
      frame_err_q <= rx_ferr;
      if (push)   wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (tx_pop) rd_ptr_q   <= rd_ptr_q + 1'b1;
      if (drop)   overflow_q <= 1'b1;
      if (rx_done) data_out_q <= rx_shift_q;
      if (rx_done && accept) is_thai_q <= char_thai(rx_shift_q);
    end
  end

  always_ff @(posedge baud) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign RsTx       = tx_line_q;
  assign data_out   = data_out_q;
  assign received   = received_q;
  assign frame_err  = frame_err_q;
  assign is_thai    = is_thai_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: a filtered DUT (FIFO_DEPTH=4) plus an
// unfiltered twin sharing the RX line, clock and reset.
module tb_uart_echo_fifo;
  logic       baud = 1'b0;
  logic       reset, RsRx, tx_hold;
  logic       RsTx, received, frame_err, is_thai, overflow;
  logic [7:0] data_out;
  logic [2:0] fifo_count;
  logic       RsTx_nf, received_nf, frame_err_nf, is_thai_nf, overflow_nf;
  logic [7:0] data_out_nf;
  logic [4:0] fifo_count_nf;

  int checks = 0, failures = 0, cyc = 0;
  int recv_cnt = 0, recv_cyc = 0, ferr_cnt = 0, pulse_bad = 0;
  bit recv_prev = 1'b0;
  bit mon_busy = 1'b0, mon_stop = 1'b0;
  int mon_off = 0, mon_start = 0, mon_fh = 0, mon_starts = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] tx_bytes[$];
  int         tx_start[$];
  int         tx_fh[$];
  bit         tx_stop[$];

  uart_echo_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4), .FILTER_EN(1)) u_dut (
    .baud(baud), .reset(reset), .RsRx(RsRx), .tx_hold(tx_hold), .RsTx(RsTx),
    .data_out(data_out), .received(received), .frame_err(frame_err), .is_thai(is_thai),
    .overflow(overflow), .fifo_count(fifo_count));

  uart_echo_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(16), .FILTER_EN(0)) u_dut_nf (
    .baud(baud), .reset(reset), .RsRx(RsRx), .tx_hold(tx_hold), .RsTx(RsTx_nf),
    .data_out(data_out_nf), .received(received_nf), .frame_err(frame_err_nf), .is_thai(is_thai_nf),
    .overflow(overflow_nf), .fifo_count(fifo_count_nf));

  always #5 baud = ~baud;

  initial forever begin
    @(posedge baud);
    cyc++;
  end

  // RX pulse counters and TX line decoder for the filtered DUT.
  initial forever begin
    @(negedge baud);
    if (received) begin
      recv_cnt++;
      recv_cyc = cyc;
      if (recv_prev) pulse_bad++;
    end
    recv_prev = received;
    if (frame_err) ferr_cnt++;
    if (reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (RsTx == 1'b0) begin
        mon_busy = 1'b1; mon_off = 0; mon_start = cyc; mon_fh = -1; mon_byte = 8'h00;
        mon_starts++;
      end
    end else begin
      mon_off++;
      if (RsTx && mon_fh < 0) mon_fh = mon_off;
      if (mon_off >= 24 && mon_off < 152 && ((mon_off - 24) % 16) == 0)
        mon_byte[(mon_off - 24) / 16] = RsTx;
      if (mon_off == 152) mon_stop = RsTx;
      if (mon_off == 159) begin
        tx_bytes.push_back(mon_byte);
        tx_start.push_back(mon_start);
        tx_fh.push_back(mon_fh);
        tx_stop.push_back(mon_stop);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge baud);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RsRx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      tick(16);
    end
    RsRx = stop_bit;
    tick(16);
    RsRx = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (tx_bytes.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (tx_bytes.size() < n) begin
      failures++;
      $display("FAIL frame_wait: got %0d frames, required %0d", tx_bytes.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; RsRx = 1'b1; tx_hold = 1'b0;
    tick(3);
    checks++; if (RsTx !== 1'b1) begin failures++; $display("FAIL rst_rstx: got %b required 1", RsTx); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", data_out); end
    checks++; if (received !== 1'b0) begin failures++; $display("FAIL rst_recv: got %b required 0", received); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr: got %b required 0", frame_err); end
    checks++; if (is_thai !== 1'b0) begin failures++; $display("FAIL rst_thai: got %b required 0", is_thai); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b required 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_basic_echo;
    int r0 = recv_cnt, f0 = tx_bytes.size();
    send_byte(8'h41, 1'b1);
    wait_frames(f0 + 1, 300);
    checks++; if (recv_cnt - r0 != 1) begin failures++; $display("FAIL basic_recv: got %0d pulses required 1", recv_cnt - r0); end
    checks++; if (data_out !== 8'h41) begin failures++; $display("FAIL basic_data: got %h required 41", data_out); end
    checks++; if (is_thai !== 1'b0) begin failures++; $display("FAIL basic_thai: got %b required 0", is_thai); end
    checks++; if (tx_start[f0] - recv_cyc != 1) begin failures++; $display("FAIL basic_latency: got %0d required 1", tx_start[f0] - recv_cyc); end
    checks++; if (tx_bytes[f0] !== 8'h41) begin failures++; $display("FAIL basic_echo: got %h required 41", tx_bytes[f0]); end
    checks++; if (tx_fh[f0] != 16) begin failures++; $display("FAIL basic_startlen: got %0d required 16", tx_fh[f0]); end
    checks++; if (tx_stop[f0] !== 1'b1) begin failures++; $display("FAIL basic_stop: got %b required 1", tx_stop[f0]); end
    tick(200);
    checks++; if (tx_bytes.size() != f0 + 1) begin failures++; $display("FAIL basic_single: got %0d frames required %0d", tx_bytes.size(), f0 + 1); end
    checks++; if (RsTx !== 1'b1) begin failures++; $display("FAIL basic_idle: got %b required 1", RsTx); end
  endtask

  task automatic test_filter;
    int r0 = recv_cnt, f0 = tx_bytes.size();
    send_byte(8'hA1, 1'b1);
    send_byte(8'h0D, 1'b1);
    tick(4);
    checks++; if (recv_cnt - r0 != 2) begin failures++; $display("FAIL filt_recv: got %0d pulses required 2", recv_cnt - r0); end
    checks++; if (data_out !== 8'h0D) begin failures++; $display("FAIL filt_data: got %h required 0d", data_out); end
    checks++; if (is_thai !== 1'b1) begin failures++; $display("FAIL filt_thai: got %b required 1", is_thai); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL filt_count: got %0d required 0", fifo_count); end
    wait_frames(f0 + 1, 300);
    tick(200);
    checks++; if (tx_bytes.size() != f0 + 1) begin failures++; $display("FAIL filt_frames: got %0d required %0d", tx_bytes.size(), f0 + 1); end
    checks++; if (tx_bytes[f0] !== 8'hA1) begin failures++; $display("FAIL filt_echo: got %h required a1", tx_bytes[f0]); end
    checks++; if (pulse_bad != 0) begin failures++; $display("FAIL recv_pulse_width: got %0d long pulses required 0", pulse_bad); end
  endtask

  task automatic test_overflow;
    int f0 = tx_bytes.size();
    logic [7:0] exp_b;
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), 1'b1);
    tick(4);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_full: got %0d required 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b required 0", overflow); end
    send_byte(8'h65, 1'b1);
    tick(4);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1", overflow); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count5: got %0d required 4", fifo_count); end
    send_byte(8'h66, 1'b1);
    tick(4);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count6: got %0d required 4", fifo_count); end
    checks++; if (tx_bytes.size() != f0) begin failures++; $display("FAIL ovf_hold: got %0d frames required %0d", tx_bytes.size(), f0); end
    tx_hold = 1'b0;
    wait_frames(f0 + 4, 1000);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h61 + 8'(i);
      checks++; if (tx_bytes[f0 + i] !== exp_b) begin failures++; $display("FAIL ovf_order%0d: got %h required %h", i, tx_bytes[f0 + i], exp_b); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (tx_start[f0 + i] - tx_start[f0 + i - 1] != 160) begin failures++; $display("FAIL ovf_b2b%0d: got gap %0d required 160", i, tx_start[f0 + i] - tx_start[f0 + i - 1]); end
    end
    tick(200);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ovf_drain: got %0d required 0", fifo_count); end
    checks++; if (tx_bytes.size() != f0 + 4) begin failures++; $display("FAIL ovf_frames: got %0d required %0d", tx_bytes.size(), f0 + 4); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_frame_err;
    int r0 = recv_cnt, e0 = ferr_cnt, f0 = tx_bytes.size();
    send_byte(8'h55, 1'b0);
    tick(20);
    checks++; if (ferr_cnt - e0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d required 1", ferr_cnt - e0); end
    checks++; if (recv_cnt != r0) begin failures++; $display("FAIL ferr_norecv: got %0d pulses required 0", recv_cnt - r0); end
    checks++; if (data_out !== 8'h66) begin failures++; $display("FAIL ferr_data: got %h required 66", data_out); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ferr_count: got %0d required 0", fifo_count); end
    tick(200);
    checks++; if (tx_bytes.size() != f0) begin failures++; $display("FAIL ferr_noecho: got %0d frames required %0d", tx_bytes.size(), f0); end
    send_byte(8'h42, 1'b1);
    wait_frames(f0 + 1, 300);
    checks++; if (recv_cnt - r0 != 1) begin failures++; $display("FAIL ferr_next_recv: got %0d required 1", recv_cnt - r0); end
    checks++; if (data_out !== 8'h42) begin failures++; $display("FAIL ferr_next_data: got %h required 42", data_out); end
    checks++; if (tx_bytes[f0] !== 8'h42) begin failures++; $display("FAIL ferr_next_echo: got %h required 42", tx_bytes[f0]); end
  endtask

  task automatic test_glitch;
    int r0 = recv_cnt, e0 = ferr_cnt, f0 = tx_bytes.size();
    RsRx = 1'b0;
    tick(4);
    RsRx = 1'b1;
    tick(40);
    checks++; if (recv_cnt != r0) begin failures++; $display("FAIL glitch_recv: got %0d pulses required 0", recv_cnt - r0); end
    checks++; if (ferr_cnt != e0) begin failures++; $display("FAIL glitch_ferr: got %0d pulses required 0", ferr_cnt - e0); end
    send_byte(8'h43, 1'b1);
    tick(4);
    checks++; if (recv_cnt - r0 != 1) begin failures++; $display("FAIL glitch_next_recv: got %0d required 1", recv_cnt - r0); end
    checks++; if (data_out !== 8'h43) begin failures++; $display("FAIL glitch_next_data: got %h required 43", data_out); end
    wait_frames(f0 + 1, 300);
    checks++; if (tx_bytes[f0] !== 8'h43) begin failures++; $display("FAIL glitch_echo: got %h required 43", tx_bytes[f0]); end
  endtask

  task automatic test_reset_mid;
    int s0, k, f0;
    tx_hold = 1'b1;
    send_byte(8'h40, 1'b1);
    send_byte(8'h45, 1'b1);
    tick(4);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL rmid_fill: got %0d required 2", fifo_count); end
    s0 = mon_starts;
    f0 = tx_bytes.size();
    tx_hold = 1'b0;
    k = 0;
    while (mon_starts == s0 && k < 20) begin tick(1); k++; end
    checks++; if (mon_starts == s0) begin failures++; $display("FAIL rmid_start: got no frame start, required one"); end
    tick(50);
    checks++; if (RsTx !== 1'b0) begin failures++; $display("FAIL rmid_midframe: got %b required 0", RsTx); end
    reset = 1'b1;
    #1;
    checks++; if (RsTx !== 1'b1) begin failures++; $display("FAIL rmid_rstx: got %b required 1", RsTx); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmid_count: got %0d required 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_ovf: got %b required 0", overflow); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h required 00", data_out); end
    tick(3);
    reset = 1'b0;
    tick(200);
    checks++; if (RsTx !== 1'b1) begin failures++; $display("FAIL rmid_after: got %b required 1", RsTx); end
    checks++; if (tx_bytes.size() != f0) begin failures++; $display("FAIL rmid_frames: got %0d required %0d", tx_bytes.size(), f0); end
  endtask

  task automatic test_nofilter;
    int k, f0 = tx_bytes.size();
    logic [7:0] got;
    tx_hold = 1'b1;
    send_byte(8'h0D, 1'b1);
    tick(4);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL nf_main_count: got %0d required 0", fifo_count); end
    checks++; if (data_out !== 8'h0D) begin failures++; $display("FAIL nf_main_data: got %h required 0d", data_out); end
    checks++; if (fifo_count_nf !== 5'd1) begin failures++; $display("FAIL nf_count: got %0d required 1", fifo_count_nf); end
    checks++; if (data_out_nf !== 8'h0D) begin failures++; $display("FAIL nf_data: got %h required 0d", data_out_nf); end
    checks++; if ({is_thai_nf, overflow_nf, frame_err_nf, received_nf} !== 4'b0000) begin failures++; $display("FAIL nf_flags: got %b required 0000", {is_thai_nf, overflow_nf, frame_err_nf, received_nf}); end
    tx_hold = 1'b0;
    k = 0;
    while (RsTx_nf !== 1'b0 && k < 10) begin tick(1); k++; end
    checks++; if (RsTx_nf !== 1'b0) begin failures++; $display("FAIL nf_start: got %b required 0", RsTx_nf); end
    tick(8);
    checks++; if (RsTx_nf !== 1'b0) begin failures++; $display("FAIL nf_startbit: got %b required 0", RsTx_nf); end
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(16);
      got[i] = RsTx_nf;
    end
    tick(16);
    checks++; if (RsTx_nf !== 1'b1) begin failures++; $display("FAIL nf_stop: got %b required 1", RsTx_nf); end
    checks++; if (got !== 8'h0D) begin failures++; $display("FAIL nf_echo: got %h required 0d", got); end
    tick(20);
    checks++; if (tx_bytes.size() != f0) begin failures++; $display("FAIL nf_main_noecho: got %0d frames required %0d", tx_bytes.size(), f0); end
  endtask

  initial begin
    test_reset;
    test_basic_echo;
    test_filter;
    test_overflow;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    test_nofilter;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
